fetch_controller: RTL

FETCH_CONTROLLER -- requirements
Module: fetch_controller

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_skid_buffer.sv | 51 +++++
 rtl/fetch_controller.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch controller.
//   fetch_state_e : FSM encoding (IDLE / FETCH / HOLD)
//   ZERO_WORD     : value presented on instr_out / pc_out after reset
//   PC_STEP       : byte distance between sequential fetches
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
  localparam int unsigned PC_STEP   = 4;

endpackage

// File: rtl/fetch_skid_buffer.sv
// fetch_skid_buffer: one-entry holding slot for an instruction that returned
// while the fetch output was stalled.
//   clk, rst_n      : clock, asynchronous active-low reset
//   load_i          : capture data_i/pc_i and mark full
//   unload_i        : mark empty (entry has been moved to the output)
//   clear_i         : drop the entry (redirect); wins over load/unload
//   data_i, pc_i    : instruction word and its pc (+4) to capture
//   full_o          : entry present
//   data_o, pc_o    : stored instruction word and pc
module fetch_skid_buffer
  import fetch_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         unload_i,
  input  logic         clear_i,
  input  logic [W-1:0] data_i,
  input  logic [W-1:0] pc_i,
  output logic         full_o,
  output logic [W-1:0] data_o,
  output logic [W-1:0] pc_o
);

  logic         full_q;
  logic [W-1:0] data_q;
  logic [W-1:0] pc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= W'(ZERO_WORD);
      pc_q   <= W'(ZERO_WORD);
    end else if (clear_i) begin
      full_q <= 1'b0;
    end else if (load_i) begin
      full_q <= 1'b1;
      data_q <= data_i;
      pc_q   <= pc_i;
    end else if (unload_i) begin
      full_q <= 1'b0;
    end
  end

  assign full_o = full_q;
  assign data_o = data_q;
  assign pc_o   = pc_q;

endmodule

// File: rtl/fetch_controller.sv
// fetch_controller: sequential instruction fetcher with redirect and a
// one-entry skid buffer behind a stallable output register.
//   clk, rst            : clock, asynchronous active-low reset
//   stall_in            : downstream frozen, presented instruction not consumed
//   branch_taken        : one-cycle redirect pulse to branch_address (word aligned)
//   mem_req, mem_addr   : read request / address to instruction memory
//   mem_ready, mem_rdata: request completion and returned instruction word
//   instr_valid, instr_out, pc_out : registered fetch result (pc_out = addr + 4)
//   fetch_busy          : request outstanding and not completing this cycle
//   dbg_state_o         : current FSM state
// Memory handshake: a request is live in every FETCH cycle with mem_addr held
// constant; the cycle with mem_ready=1 completes it and mem_rdata is taken in
// that same cycle. mem_ready outside FETCH is ignored.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_in,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_address,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_rdata,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] instr_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic              fetch_busy,
  output logic [1:0]        dbg_state_o
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] target_q, target_d;
  logic              valid_q, valid_d;
  logic              pend_q, pend_d;

  logic              skid_load, skid_unload, skid_clear, skid_full;
  logic [ADDR_W-1:0] skid_data, skid_pc;

  logic [ADDR_W-1:0] branch_tgt;
  logic [ADDR_W-1:0] next_pc;
  logic              out_blocked;

  assign branch_tgt  = branch_address & ~ADDR_W'(2'b11);
  assign next_pc     = fetch_pc_q + ADDR_W'(PC_STEP);
  // Output holds a valid instruction that downstream will not take this cycle.
  assign out_blocked = valid_q && stall_in;

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    instr_d     = instr_q;
    pc_d        = pc_q;
    target_d    = target_q;
    valid_d     = valid_q;
    pend_d      = pend_q;
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    skid_clear  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
        if (branch_taken) fetch_pc_d = branch_tgt;
      end

      ST_FETCH: begin
        if (branch_taken && !mem_ready) begin
          // Address must stay put until memory answers; remember the target.
          pend_d     = 1'b1;
          target_d   = branch_tgt;
          valid_d    = 1'b0;
          skid_clear = 1'b1;
        end else if (branch_taken) begin
          fetch_pc_d = branch_tgt;
          pend_d     = 1'b0;
          valid_d    = 1'b0;
          skid_clear = 1'b1;
        end else if (pend_q) begin
          // Response belongs to the abandoned path: drop it, go to target.
          if (mem_ready) begin
            fetch_pc_d = target_q;
            pend_d     = 1'b0;
          end
        end else if (mem_ready) begin
          fetch_pc_d = next_pc;
          if (out_blocked) begin
            skid_load = 1'b1;
            state_d   = ST_HOLD;
          end else begin
            valid_d = 1'b1;
            instr_d = mem_rdata;
            pc_d    = next_pc;
          end
        end else if (!out_blocked) begin
          valid_d = 1'b0;
        end
      end

      ST_HOLD: begin
        if (branch_taken) begin
          fetch_pc_d = branch_tgt;
          valid_d    = 1'b0;
          skid_clear = 1'b1;
          state_d    = ST_FETCH;
        end else if (!stall_in) begin
          valid_d     = skid_full;
          instr_d     = skid_data;
          pc_d        = skid_pc;
          skid_unload = 1'b1;
          state_d     = ST_FETCH;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      instr_q    <= ADDR_W'(ZERO_WORD);
      pc_q       <= ADDR_W'(ZERO_WORD);
      target_q   <= RESET_PC;
      valid_q    <= 1'b0;
      pend_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      target_q   <= target_d;
      valid_q    <= valid_d;
      pend_q     <= pend_d;
    end
  end

  fetch_skid_buffer #(.W(ADDR_W)) u_skid (
    .clk      (clk),
    .rst_n    (rst),
    .load_i   (skid_load),
    .unload_i (skid_unload),
    .clear_i  (skid_clear),
    .data_i   (mem_rdata),
    .pc_i     (next_pc),
    .full_o   (skid_full),
    .data_o   (skid_data),
    .pc_o     (skid_pc)
  );

  assign mem_req     = (state_q == ST_FETCH);
  assign mem_addr    = fetch_pc_q;
  assign instr_valid = valid_q;
  assign instr_out   = instr_q;
  assign pc_out      = pc_q;
  assign fetch_busy  = (state_q == ST_FETCH) && !mem_ready;
  assign dbg_state_o = state_q;

endmodule
